// File: rtl/lsq_issue.sv
// rtl/lsq_issue.sv - in-order load/store queue issuing one data-memory request at a time
// Stores wait for ROB commit; out-of-range heads retire with an exception broadcast.
module lsq_issue #(
   parameter int DEPTH   = 4,
   parameter int ROBEN_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               alloc_valid,
   input  logic               alloc_is_store,
   input  logic [ROBEN_W-1:0] alloc_roben,
   input  logic [31:0]        alloc_base,
   input  logic [31:0]        alloc_offset,
   input  logic [31:0]        alloc_data,
   input  logic               commit_store,
   input  logic [ROBEN_W-1:0] commit_roben,
   input  logic               flush,
   output logic               full,
   output logic               Read_en,
   output logic               Write_en,
   output logic [ROBEN_W-1:0] ROBEN,
   output logic [31:0]        address,
   output logic [31:0]        data,
   input  logic [31:0]        MEMU_Result,
   input  logic [ROBEN_W-1:0] MEMU_ROBEN,
   output logic               cdb_valid,
   output logic [ROBEN_W-1:0] cdb_roben,
   output logic [31:0]        cdb_value,
   output logic               cdb_exception
);
   localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0]  CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [31:0]     ADDR_MAX = 32'd1023;

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
   state_t r_state, w_state_nxt;

   logic [ROBEN_W-1:0] r_tag   [DEPTH];
   logic               r_store [DEPTH];
   logic [31:0]        r_addr  [DEPTH];
   logic [31:0]        r_data  [DEPTH];
   logic [PTR_W-1:0]   r_head, r_tail;
   logic [PTR_W:0]     r_count;

   logic               r_read_en, r_write_en, r_cdb_valid, r_cdb_exc;
   logic [ROBEN_W-1:0] r_roben, r_cdb_roben;
   logic [31:0]        r_address, r_data_out, r_cdb_value;

   logic               w_push, w_pop, w_head_valid;
   logic [ROBEN_W-1:0] w_head_tag;
   logic [31:0]        w_head_addr;
   logic               w_read_en, w_write_en, w_cdb_valid, w_cdb_exc;
   logic [ROBEN_W-1:0] w_roben, w_cdb_roben;
   logic [31:0]        w_address, w_data_out, w_cdb_value;

   assign w_head_valid = (r_count != '0);
   assign w_head_tag   = r_tag[r_head];
   assign w_head_addr  = r_addr[r_head];
   // A full queue refuses allocation even when the head retires on the same edge.
   assign w_push       = alloc_valid && (r_count != CNT_FULL);

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_read_en   = 1'b0;
      w_write_en  = 1'b0;
      w_roben     = '0;
      w_address   = '0;
      w_data_out  = '0;
      w_cdb_valid = 1'b0;
      w_cdb_exc   = 1'b0;
      w_cdb_roben = '0;
      w_cdb_value = '0;
      case (r_state)
         IDLE: begin
            if (w_head_valid) begin
               if (w_head_addr > ADDR_MAX) begin
                  w_cdb_valid = 1'b1;
                  w_cdb_exc   = 1'b1;
                  w_cdb_roben = w_head_tag;
                  w_pop       = 1'b1;
               end else if (!r_store[r_head]) begin
                  w_read_en   = 1'b1;
                  w_roben     = w_head_tag;
                  w_address   = w_head_addr;
                  w_state_nxt = WAIT;
               end else if (commit_store && (commit_roben == w_head_tag)) begin
                  w_write_en  = 1'b1;
                  w_roben     = w_head_tag;
                  w_address   = w_head_addr;
                  w_data_out  = r_data[r_head];
                  w_pop       = 1'b1;
               end
            end
         end
         WAIT: begin
            if (MEMU_ROBEN == w_head_tag) begin
               w_cdb_valid = 1'b1;
               w_cdb_roben = w_head_tag;
               w_cdb_value = MEMU_Result;
               w_pop       = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        r_state <= IDLE;
      else if (flush) r_state <= IDLE;
      else            r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + PTR_ONE;
         if (w_pop)  r_head <= r_head + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !flush) begin
         r_tag[r_tail]   <= alloc_roben;
         r_store[r_tail] <= alloc_is_store;
         r_addr[r_tail]  <= alloc_base + alloc_offset;
         r_data[r_tail]  <= alloc_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst || flush) begin
         r_read_en   <= 1'b0;
         r_write_en  <= 1'b0;
         r_roben     <= '0;
         r_address   <= '0;
         r_data_out  <= '0;
         r_cdb_valid <= 1'b0;
         r_cdb_exc   <= 1'b0;
         r_cdb_roben <= '0;
         r_cdb_value <= '0;
      end else begin
         r_read_en   <= w_read_en;
         r_write_en  <= w_write_en;
         r_roben     <= w_roben;
         r_address   <= w_address;
         r_data_out  <= w_data_out;
         r_cdb_valid <= w_cdb_valid;
         r_cdb_exc   <= w_cdb_exc;
         r_cdb_roben <= w_cdb_roben;
         r_cdb_value <= w_cdb_value;
      end
   end

   assign full          = (r_count == CNT_FULL);
   assign Read_en       = r_read_en;
   assign Write_en      = r_write_en;
   assign ROBEN         = r_roben;
   assign address       = r_address;
   assign data          = r_data_out;
   assign cdb_valid     = r_cdb_valid;
   assign cdb_roben     = r_cdb_roben;
   assign cdb_value     = r_cdb_value;
   assign cdb_exception = r_cdb_exc;
endmodule

// File: tb/tb_lsq_issue.sv
// tb/tb_lsq_issue.sv - scoreboard bench for lsq_issue
// Stimulus pushes expected memory requests and CDB broadcasts; a negedge monitor pops and compares.
module tb_lsq_issue;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alloc_valid, alloc_is_store, commit_store, flush;
   logic [4:0]  alloc_roben, commit_roben, ROBEN, MEMU_ROBEN, cdb_roben;
   logic [31:0] alloc_base, alloc_offset, alloc_data;
   logic        full, Read_en, Write_en, cdb_valid, cdb_exception;
   logic [31:0] address, data, MEMU_Result, cdb_value;

   int n_checks = 0;
   int n_fail   = 0;
   logic [127:0] exp_req[$];
   logic [127:0] exp_cdb[$];

   logic        stall = 1'b0;
   logic [4:0]  pend_tag = '0;
   logic [31:0] pend_addr = '0;

   lsq_issue #(.DEPTH(4), .ROBEN_W(5)) dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_is_store(alloc_is_store), .alloc_roben(alloc_roben),
      .alloc_base(alloc_base), .alloc_offset(alloc_offset), .alloc_data(alloc_data),
      .commit_store(commit_store), .commit_roben(commit_roben), .flush(flush),
      .full(full), .Read_en(Read_en), .Write_en(Write_en), .ROBEN(ROBEN),
      .address(address), .data(data),
      .MEMU_Result(MEMU_Result), .MEMU_ROBEN(MEMU_ROBEN),
      .cdb_valid(cdb_valid), .cdb_roben(cdb_roben), .cdb_value(cdb_value),
      .cdb_exception(cdb_exception)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_at(input logic [31:0] a);
      return (a == 32'd104) ? 32'h55 : {~a[15:0], a[15:0]};
   endfunction

   // Memory answers the latched read; a stall returns a deliberately wrong tag.
   always @(negedge clk) if (Read_en) begin
      pend_tag  = ROBEN;
      pend_addr = address;
   end
   always_comb begin
      MEMU_ROBEN  = stall ? (pend_tag ^ 5'd1) : pend_tag;
      MEMU_Result = mem_at(pend_addr);
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] out_vec();
      return {17'd0, full, Read_en, Write_en, ROBEN, address, data,
              cdb_valid, cdb_roben, cdb_value, cdb_exception};
   endfunction

   task automatic exp_load(input logic [4:0] tag, input logic [31:0] a);
      exp_req.push_back({59'd0, 1'b0, tag, a, 32'd0});
      exp_cdb.push_back({90'd0, tag, 1'b0, mem_at(a)});
   endtask

   task automatic exp_bad(input logic [4:0] tag);
      exp_cdb.push_back({90'd0, tag, 1'b1, 32'd0});
   endtask

   task automatic alloc(input logic st, input logic [4:0] tag, input logic [31:0] b,
                        input logic [31:0] o, input logic [31:0] d);
      alloc_valid = 1'b1; alloc_is_store = st; alloc_roben = tag;
      alloc_base = b; alloc_offset = o; alloc_data = d;
      @(negedge clk);
      alloc_valid = 1'b0;
   endtask

   task automatic drain(input int n);
      repeat (n) @(negedge clk);
      chk("req_queue_empty", 128'(exp_req.size()), 128'd0);
      chk("cdb_queue_empty", 128'(exp_cdb.size()), 128'd0);
   endtask

   always @(negedge clk) begin
      logic [127:0] e;
      if (Read_en && Write_en) chk("rd_wr_exclusive", 128'd1, 128'd0);
      if (Read_en || Write_en) begin
         if (exp_req.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_req: we=%0b tag=%0d addr=%0h required none", Write_en, ROBEN, address);
         end else begin
            e = exp_req.pop_front();
            chk("mem_req", {59'd0, Write_en, ROBEN, address, Write_en ? data : 32'd0}, e);
         end
      end
      if (cdb_valid) begin
         if (exp_cdb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_cdb: tag=%0d val=%0h exc=%0b required none", cdb_roben, cdb_value, cdb_exception);
         end else begin
            e = exp_cdb.pop_front();
            chk("cdb", {90'd0, cdb_roben, cdb_exception, cdb_value}, e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic found;
      alloc_valid = 0; alloc_is_store = 0; alloc_roben = 0; alloc_base = 0;
      alloc_offset = 0; alloc_data = 0; commit_store = 0; commit_roben = 0; flush = 0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", out_vec(), 128'd0);
      chk("reset_count", 128'(dut.r_count), 128'd0);
      rst = 1'b0;

      // Load with latency checks
      exp_load(5'd3, 32'd104);
      alloc(1'b0, 5'd3, 32'd100, 32'd4, 32'd0);
      chk("ld_e0_no_read", 128'(Read_en), 128'd0);
      @(negedge clk);
      chk("ld_e1_read", 128'(Read_en), 128'd1);
      chk("ld_e1_addr", 128'(address), 128'd104);
      @(negedge clk);
      chk("ld_e2_read_drop", 128'(Read_en), 128'd0);
      chk("ld_e2_cdb", {cdb_valid, cdb_roben, cdb_value}, {1'b1, 5'd3, 32'h55});
      @(negedge clk);
      chk("ld_cdb_pulse", 128'(cdb_valid), 128'd0);

      // Store waits for matching commit
      exp_req.push_back({59'd0, 1'b1, 5'd7, 32'd8, 32'hAA});
      alloc(1'b1, 5'd7, 32'd8, 32'd0, 32'hAA);
      repeat (5) begin
         @(negedge clk);
         chk("st_no_commit", 128'(Write_en), 128'd0);
      end
      commit_store = 1'b1; commit_roben = 5'd6;
      @(negedge clk);
      chk("st_wrong_tag", 128'(Write_en), 128'd0);
      commit_roben = 5'd7;
      @(negedge clk);
      chk("st_write", {Write_en, address, data}, {1'b1, 32'd8, 32'hAA});
      commit_store = 1'b0;
      @(negedge clk);
      chk("st_write_pulse", 128'(Write_en), 128'd0);
      chk("st_count", 128'(dut.r_count), 128'd0);

      // Address range boundary
      exp_bad(5'd9);
      alloc(1'b0, 5'd9, 32'd1020, 32'd8, 32'd0);
      @(negedge clk);
      chk("bad_ld_cdb", {cdb_valid, cdb_exception, cdb_value, Read_en}, {1'b1, 1'b1, 32'd0, 1'b0});
      @(negedge clk);
      chk("bad_ld_count", 128'(dut.r_count), 128'd0);
      exp_load(5'd10, 32'd1023);
      alloc(1'b0, 5'd10, 32'd1000, 32'd23, 32'd0);
      exp_bad(5'd11);
      alloc(1'b1, 5'd11, 32'd1024, 32'd0, 32'h77);
      drain(8);

      // Tag mismatch holds WAIT
      stall = 1'b1;
      exp_load(5'd12, 32'd200);
      alloc(1'b0, 5'd12, 32'd200, 32'd0, 32'd0);
      repeat (4) begin
         @(negedge clk);
         chk("mismatch_no_cdb", 128'(cdb_valid), 128'd0);
      end
      stall = 1'b0;
      drain(4);

      // Fill to full; fifth alloc coincides with a pop and must be dropped
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_load(5'(21 + i), 32'(400 + 4 * i));
         alloc(1'b0, 5'(21 + i), 32'(400 + 4 * i), 32'd0, 32'd0);
      end
      chk("full_set", 128'(full), 128'd1);
      stall = 1'b0;
      alloc(1'b0, 5'd25, 32'd600, 32'd0, 32'd0);
      chk("full_ignore_count", 128'(dut.r_count), 128'd3);
      chk("full_clear", 128'(full), 128'd0);
      drain(20);
      for (int i = 0; i < 4; i++) begin
         exp_load(5'(26 + i), 32'(500 + 4 * i));
         alloc(1'b0, 5'(26 + i), 32'(500 + 4 * i), 32'd0, 32'd0);
      end
      drain(20);

      // Flush while the read is on the bus, with a competing allocation
      exp_req.push_back({59'd0, 1'b0, 5'd20, 32'd300, 32'd0});
      alloc(1'b0, 5'd20, 32'd300, 32'd0, 32'd0);
      found = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (Read_en) begin found = 1'b1; break; end
         @(negedge clk);
      end
      chk("flush_read_seen", 128'(found), 128'd1);
      flush = 1'b1;
      alloc_valid = 1'b1; alloc_is_store = 1'b0; alloc_roben = 5'd31;
      alloc_base = 32'd40; alloc_offset = 32'd0;
      @(negedge clk);
      flush = 1'b0; alloc_valid = 1'b0;
      chk("flush_outputs", {cdb_valid, Read_en, full}, 128'd0);
      chk("flush_count", 128'(dut.r_count), 128'd0);
      drain(5);

      // Reset in the middle of WAIT with three entries
      stall = 1'b1;
      exp_req.push_back({59'd0, 1'b0, 5'd1, 32'd40, 32'd0});
      alloc(1'b0, 5'd1, 32'd40, 32'd0, 32'd0);
      alloc(1'b0, 5'd2, 32'd44, 32'd0, 32'd0);
      alloc(1'b0, 5'd3, 32'd48, 32'd0, 32'd0);
      chk("pre_reset_count", 128'(dut.r_count), 128'd3);
      #2 rst = 1'b1;
      #1 chk("async_reset_outputs", out_vec(), 128'd0);
      @(negedge clk);
      rst = 1'b0;
      stall = 1'b0;
      drain(6);
      chk("post_reset_count", 128'(dut.r_count), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/lsq_issue.md
LSQ_ISSUE -- requirements
Module: lsq_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving queue entry count (power of two, >=2).
REQ-002 SHALL have parameter ROBEN_W, default 5, giving ROB tag width.
REQ-003 SHALL have ports: clk in 1, the single clock; rst in 1, asynchronous active-high reset.
REQ-004 SHALL have ports: alloc_valid in 1, allocate request; alloc_is_store in 1; alloc_roben in ROBEN_W; alloc_base in 32; alloc_offset in 32; alloc_data in 32, store data.
REQ-005 SHALL have ports: commit_store in 1 and commit_roben in ROBEN_W, ROB permission for a store to write; flush in 1, pipeline squash.
REQ-006 SHALL have ports: full out 1; Read_en out 1; Write_en out 1; ROBEN out ROBEN_W; address out 32; data out 32. These are the request to the data memory.
REQ-007 SHALL have ports: MEMU_Result in 32 and MEMU_ROBEN in ROBEN_W, the data memory response.
REQ-008 SHALL have ports: cdb_valid out 1; cdb_roben out ROBEN_W; cdb_value out 32; cdb_exception out 1.

Function
REQ-009 SHALL hold entries in a circular FIFO with head/tail pointers wrapping modulo DEPTH and a count of 0..DEPTH.
REQ-010 SHALL write an entry on a clk edge with alloc_valid=1 and count<DEPTH, storing tag, type, data, and effective address alloc_base+alloc_offset modulo 2^32.
REQ-011 SHALL drive full=1 exactly when registered count==DEPTH, and SHALL ignore alloc_valid while full, even if the head pops on the same edge.
REQ-012 SHALL use FSM states IDLE and WAIT, with only one memory request outstanding.
REQ-013 In IDLE with a valid head load, SHALL register Read_en=1, ROBEN=head tag, address=head address for exactly one cycle, then enter WAIT.
REQ-014 In IDLE with a valid head store, SHALL issue only on an edge where commit_store=1 and commit_roben==head tag.
REQ-015 A store issue SHALL assert Write_en=1 with data=head data for one cycle, pop the head, and stay in IDLE with no CDB broadcast.
REQ-016 SHALL never assert Read_en and Write_en together.
REQ-017 SHALL treat a head address with address>1023 (unsigned) as invalid.
REQ-018 For an invalid head, SHALL assert no enable and SHALL assert cdb_valid=1, cdb_exception=1, cdb_value=0, cdb_roben=head tag for one cycle, then pop.
REQ-019 An invalid store SHALL take the REQ-018 path without waiting for commit.
REQ-020 In WAIT, on the next edge, SHALL compare MEMU_ROBEN with the issued tag.
REQ-021 On a WAIT match, SHALL pulse cdb_valid=1, cdb_exception=0, cdb_value=MEMU_Result, cdb_roben=tag for one cycle, pop the head, and return to IDLE.
REQ-022 On a WAIT mismatch, SHALL remain in WAIT with no CDB output.
REQ-023 Load latency SHALL be: allocation edge E0, request driven E1..E2, cdb_valid driven E2..E3 for an empty queue with no flush.
REQ-024 Allocation and pop on the same edge SHALL leave count unchanged.
REQ-025 flush=1 on an edge SHALL clear count, reset both pointers to 0, force IDLE, deassert all enables, and suppress cdb_valid.
REQ-026 flush SHALL take priority over allocation, issue, and response capture on the same edge; a response arriving after a flush SHALL be discarded.

Reset
REQ-027 While rst=1, SHALL asynchronously force FSM=IDLE, count=0, pointers=0, and all outputs to 0.
REQ-028 Asserting rst mid-WAIT SHALL drop the outstanding request with no CDB output.

Verification
REQ-029 Load: alloc base=100, offset=4, tag=3 into empty queue, memory word 104=0x55 -> Read_en one cycle with address=104, ROBEN=3; next cycle cdb_valid=1, cdb_roben=3, cdb_value=0x55.
REQ-030 Store gating: alloc store tag=7, address=8, data=0xAA; hold commit_store=0 for 5 cycles -> no Write_en; commit_store=1, commit_roben=7 -> Write_en one cycle with address=8, data=0xAA; count becomes 0; no cdb_valid.
REQ-031 Range: alloc load base=1020, offset=8 (1028) -> no Read_en; cdb_valid=1, cdb_exception=1, cdb_value=0; queue empties.
REQ-032 Full/wrap: allocate 4 loads -> full=1; a 5th allocation is ignored; drain all 4 -> CDB tags appear in allocation order; allocate 4 more -> pointers wrap and order is preserved.
REQ-033 Flush in WAIT: flush on the cycle a load's Read_en is high -> no cdb_valid on the following edges; count=0; full=0.
REQ-034 Reset: assert rst mid-WAIT with 3 entries queued -> all outputs 0 immediately; count=0 after release.
